// File: rtl/bus_arbiter_if.sv
// Bus-ownership signal bundle between the arbiter and the C64 system glue.
// The slave side is the arbiter itself; the master side is the logic that drives requests.
interface bus_arbiter_if #(
  parameter int DOTS_PER_PHI = 8
);
  localparam int PHASE_W = $clog2(DOTS_PER_PHI);

  logic               vic_steal;
  logic               dma_req;
  logic               cpu_we;
  logic               phi0;
  logic [PHASE_W-1:0] phase;
  logic               ba;
  logic               aec;
  logic               cpu_rdy;
  logic               grant_dma;
  logic [1:0]         bus_sel;

  modport slave (
    input  vic_steal, dma_req, cpu_we,
    output phi0, phase, ba, aec, cpu_rdy, grant_dma, bus_sel
  );

  modport master (
    output vic_steal, dma_req, cpu_we,
    input  phi0, phase, ba, aec, cpu_rdy, grant_dma, bus_sel
  );
endinterface

// File: rtl/bus_arbiter.sv
// C64 bus arbiter: splits dot_clk into phi0 cycles and hands phi2 to the CPU, DMA or a stolen VIC cycle.
// Requests are sampled on the last dot of each phi0 cycle; every output is a flop.
module bus_arbiter #(
  parameter int DOTS_PER_PHI = 8,
  parameter int BA_LEAD      = 3
) (
  input  logic           dot_clk,
  input  logic           res_n,
  bus_arbiter_if.slave   arb
);

  localparam int PHASE_W = $clog2(DOTS_PER_PHI);
  localparam int LEAD_W  = $clog2(BA_LEAD + 1);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DOTS_PER_PHI - 1);
  localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(DOTS_PER_PHI / 2);
  localparam logic [LEAD_W-1:0]  LEAD_LOAD  = LEAD_W'(BA_LEAD - 1);

  localparam logic [2:0] ST_CPU      = 3'd0;
  localparam logic [2:0] ST_BA_WAIT  = 3'd1;
  localparam logic [2:0] ST_VIC_OWN  = 3'd2;
  localparam logic [2:0] ST_DMA_WAIT = 3'd3;
  localparam logic [2:0] ST_DMA_OWN  = 3'd4;

  localparam logic [1:0] SEL_VIC = 2'b00;
  localparam logic [1:0] SEL_CPU = 2'b01;
  localparam logic [1:0] SEL_DMA = 2'b10;

  logic [PHASE_W-1:0] r_phase;
  logic [2:0]         r_state;
  logic [LEAD_W-1:0]  r_lead_cnt;
  logic               r_phi0;
  logic               r_ba;
  logic               r_aec;
  logic               r_cpu_rdy;
  logic               r_grant_dma;
  logic [1:0]         r_bus_sel;

  logic               w_boundary;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic [2:0]         w_fsm_state;
  logic [LEAD_W-1:0]  w_fsm_lead;
  logic [2:0]         w_state_nxt;
  logic [LEAD_W-1:0]  w_lead_nxt;
  logic               w_phi2_nxt;
  logic               w_ba_nxt;
  logic [1:0]         w_sel_nxt;

  assign w_boundary  = (r_phase == PHASE_LAST);
  assign w_phase_nxt = w_boundary ? '0 : r_phase + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path can leave it
  // holding its old value and infer a latch.
  always_comb begin
    w_fsm_state = r_state;
    w_fsm_lead  = r_lead_cnt;
    case (r_state)
      ST_CPU: begin
        if (arb.vic_steal) begin
          w_fsm_state = ST_BA_WAIT;
          w_fsm_lead  = LEAD_LOAD;
        end else if (arb.dma_req && arb.cpu_we) begin
          w_fsm_state = ST_DMA_WAIT;
        end else if (arb.dma_req) begin
          w_fsm_state = ST_DMA_OWN;
        end
      end
      ST_BA_WAIT: begin
        if (!arb.vic_steal) begin
          w_fsm_state = ST_CPU;
        end else if (r_lead_cnt == '0) begin
          w_fsm_state = ST_VIC_OWN;
        end else begin
          w_fsm_lead = r_lead_cnt - 1'b1;
        end
      end
      ST_VIC_OWN: begin
        if (!arb.vic_steal) begin
          w_fsm_state = arb.dma_req ? ST_DMA_OWN : ST_CPU;
        end
      end
      ST_DMA_WAIT: begin
        // The extra CPU cycle spent here lets a pending CPU write finish first.
        if (arb.vic_steal) begin
          w_fsm_state = ST_BA_WAIT;
          w_fsm_lead  = LEAD_LOAD;
        end else if (arb.dma_req) begin
          w_fsm_state = ST_DMA_OWN;
        end else begin
          w_fsm_state = ST_CPU;
        end
      end
      ST_DMA_OWN: begin
        if (arb.vic_steal) begin
          w_fsm_state = ST_BA_WAIT;
          w_fsm_lead  = LEAD_LOAD;
        end else if (!arb.dma_req) begin
          w_fsm_state = ST_CPU;
        end
      end
      default: begin
        w_fsm_state = ST_CPU;
        w_fsm_lead  = '0;
      end
    endcase
  end

  // Requests only take effect at the boundary, so the new owner starts cleanly at phase 0.
  assign w_state_nxt = w_boundary ? w_fsm_state : r_state;
  assign w_lead_nxt  = w_boundary ? w_fsm_lead  : r_lead_cnt;

  // Outputs are computed from the next phase/state so the flops line up with them.
  assign w_phi2_nxt = (w_phase_nxt >= PHASE_HALF);
  assign w_ba_nxt   = !((w_state_nxt == ST_BA_WAIT) || (w_state_nxt == ST_VIC_OWN));

  always_comb begin
    w_sel_nxt = SEL_VIC;
    if (w_phi2_nxt) begin
      case (w_state_nxt)
        ST_VIC_OWN: w_sel_nxt = SEL_VIC;
        ST_DMA_OWN: w_sel_nxt = SEL_DMA;
        default:    w_sel_nxt = SEL_CPU;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge dot_clk or negedge res_n) begin
    if (!res_n) begin
      r_phase     <= '0;
      r_state     <= ST_CPU;
      r_lead_cnt  <= '0;
      r_phi0      <= 1'b0;
      r_ba        <= 1'b1;
      r_aec       <= 1'b0;
      r_cpu_rdy   <= 1'b1;
      r_grant_dma <= 1'b0;
      r_bus_sel   <= SEL_VIC;
    end else begin
      r_phase     <= w_phase_nxt;
      r_state     <= w_state_nxt;
      r_lead_cnt  <= w_lead_nxt;
      r_phi0      <= w_phi2_nxt;
      r_ba        <= w_ba_nxt;
      r_aec       <= w_phi2_nxt && (w_state_nxt != ST_VIC_OWN);
      r_cpu_rdy   <= w_ba_nxt && (w_state_nxt != ST_DMA_OWN);
      r_grant_dma <= (w_state_nxt == ST_DMA_OWN);
      r_bus_sel   <= w_sel_nxt;
    end
  end

  assign arb.phase     = r_phase;
  assign arb.phi0      = r_phi0;
  assign arb.ba        = r_ba;
  assign arb.aec       = r_aec;
  assign arb.cpu_rdy   = r_cpu_rdy;
  assign arb.grant_dma = r_grant_dma;
  assign arb.bus_sel   = r_bus_sel;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: idle dot walk, a table of per-cycle request vectors with a
// scoreboard of expected bus owners, then an asynchronous reset during a VIC steal.
module tb_bus_arbiter;

  localparam int DOTS    = 8;
  localparam int BA_LEAD = 3;

  typedef enum logic [2:0] {S_CPU, S_BAW, S_VIC, S_DWT, S_DMA} st_e;

  typedef struct {
    logic steal;
    logic dma;
    logic we;
    st_e  nxt;
  } vec_t;

  logic dot_clk = 1'b0;
  logic res_n   = 1'b0;

  bus_arbiter_if #(.DOTS_PER_PHI(DOTS)) bif ();

  bus_arbiter #(
    .DOTS_PER_PHI(DOTS),
    .BA_LEAD     (BA_LEAD)
  ) dut (
    .dot_clk(dot_clk),
    .res_n  (res_n),
    .arb    (bif.slave)
  );

  always #5 dot_clk = ~dot_clk;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];
  st_e  sb[$];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {phase,phi0,ba,aec,rdy,grant,sel}=%b required %b", name, act, exp);
    end
  endtask

  function automatic logic [9:0] observed();
    return {bif.phase, bif.phi0, bif.ba, bif.aec, bif.cpu_rdy, bif.grant_dma, bif.bus_sel};
  endfunction

  // Expected outputs for a given bus state at a given dot.
  function automatic logic [9:0] expect_out(input st_e st, input logic [2:0] ph);
    logic       phi2, ba, aec, rdy, grant;
    logic [1:0] sel;
    phi2  = (ph >= 3'(DOTS / 2));
    ba    = !(st == S_BAW || st == S_VIC);
    rdy   = ba && (st != S_DMA);
    grant = (st == S_DMA);
    aec   = phi2 && (st != S_VIC);
    if (!phi2 || st == S_VIC) sel = 2'b00;
    else if (st == S_DMA)     sel = 2'b10;
    else                      sel = 2'b01;
    return {ph, phi2, ba, aec, rdy, grant, sel};
  endfunction

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(negedge dot_clk);
      n++;
    end while (bif.phase != 3'(p) && n < 64);
    if (bif.phase != 3'(p)) begin
      checks++;
      failures++;
      $display("FAIL wait_phase: phase=%0d required %0d within 64 dots", bif.phase, p);
    end
  endtask

  task automatic drive(input logic s, input logic d, input logic w);
    bif.vic_steal = s;
    bif.dma_req   = d;
    bif.cpu_we    = w;
  endtask

  task automatic add(input logic s, input logic d, input logic w, input st_e n);
    vec_t v;
    v.steal = s;
    v.dma   = d;
    v.we    = w;
    v.nxt   = n;
    vecs.push_back(v);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);

    // inputs during a cycle -> bus state of the following cycle
    add(0, 0, 0, S_CPU);
    add(0, 0, 0, S_CPU);
    add(1, 0, 0, S_BAW);   // steal held: three BA lead cycles, then VIC
    add(1, 0, 0, S_BAW);
    add(1, 0, 0, S_BAW);
    add(1, 0, 0, S_VIC);
    add(1, 0, 0, S_VIC);
    add(0, 0, 0, S_CPU);
    add(1, 0, 0, S_BAW);   // one-cycle steal pulse aborts
    add(0, 0, 0, S_CPU);
    add(0, 0, 0, S_CPU);
    add(0, 1, 1, S_DWT);   // DMA behind a CPU write
    add(0, 1, 0, S_DMA);
    add(0, 1, 0, S_DMA);
    add(0, 0, 0, S_CPU);
    add(0, 1, 1, S_DWT);   // DMA request withdrawn while waiting
    add(0, 0, 0, S_CPU);
    add(0, 1, 0, S_DMA);   // DMA with no pending write
    add(1, 1, 0, S_BAW);   // VIC pre-empts DMA
    add(1, 1, 0, S_BAW);
    add(1, 1, 0, S_BAW);
    add(1, 1, 0, S_VIC);
    add(0, 1, 0, S_DMA);   // steal ends, DMA resumes directly
    add(0, 0, 0, S_CPU);
    add(1, 1, 1, S_BAW);   // steal beats simultaneous DMA
    add(0, 1, 0, S_CPU);
    add(0, 1, 1, S_DWT);
    add(1, 1, 0, S_BAW);   // steal from DMA_WAIT
    add(0, 0, 0, S_CPU);

    repeat (3) @(negedge dot_clk);
    check("reset", observed(), expect_out(S_CPU, 3'd0));
    res_n = 1'b1;

    for (int i = 1; i <= DOTS; i++) begin
      wait_phase(i % DOTS);
      check($sformatf("idle_p%0d", i % DOTS), observed(), expect_out(S_CPU, 3'(i % DOTS)));
    end

    sb.push_back(S_CPU);
    for (int k = 0; k < vecs.size(); k++) begin
      wait_phase(1);
      check($sformatf("vec%0d_phi1", k), observed(), expect_out(sb[0], 3'd1));
      drive(~vecs[k].steal, ~vecs[k].dma, ~vecs[k].we);
      wait_phase(5);
      check($sformatf("vec%0d_phi2", k), observed(), expect_out(sb.pop_front(), 3'd5));
      drive(vecs[k].steal, vecs[k].dma, vecs[k].we);
      sb.push_back(vecs[k].nxt);
    end
    wait_phase(1);
    check("tail_phi1", observed(), expect_out(sb[0], 3'd1));
    wait_phase(5);
    check("tail_phi2", observed(), expect_out(sb.pop_front(), 3'd5));

    // Reach VIC_OWN, then reset asynchronously in the middle of phase 5.
    drive(1'b1, 1'b0, 1'b0);
    repeat (BA_LEAD + 1) wait_phase(0);
    wait_phase(5);
    check("vic_own_p5", observed(), expect_out(S_VIC, 3'd5));
    res_n = 1'b0;
    #1;
    check("reset_async", observed(), expect_out(S_CPU, 3'd0));
    drive(1'b0, 1'b0, 1'b0);
    @(negedge dot_clk);
    check("reset_hold", observed(), expect_out(S_CPU, 3'd0));
    res_n = 1'b1;
    wait_phase(1);
    check("restart_p1", observed(), expect_out(S_CPU, 3'd1));
    wait_phase(4);
    check("restart_p4", observed(), expect_out(S_CPU, 3'd4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
